sa_seq_ctrl: RTL
================

SA_SEQ_CTRL -- requirements
Module: sa_seq_ctrl

Interface
REQ-001 The block SHALL expose these parameters, one per line as name, default, meaning:
- WLOAD_CYC, 28, weight-load length in cycles (>=2).
- DRAIN_CYC, 16, post-stream drain length in cycles (>=1).
- PASS_W, 4, pass-counter width.
REQ-002 The block SHALL size its internal counter to $clog2(max(WLOAD_CYC, DRAIN_CYC)+1) bits.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; ports are listed as name, direction, width, meaning:
- clk, in, 1, clock; all state updates on its rising edge.
- rst, in, 1, synchronous active-high reset.
- start_i, in, 1, start a job; accepted only in IDLE.
- abort_i, in, 1, cancel the job; effective only outside IDLE.
- num_pass_i, in, PASS_W, number of passes; latched at start; value 0 is treated as 1.
- mode_i, in, 1, stream end rule (0: conv_done_i only; 1: conv_done_i or data_last_i); latched at start.
- stall_i, in, 1, suppresses data_enable_o in STREAM.
- data_last_i, in, 1, last data beat indication.
- conv_done_i, in, 1, convolution complete.
- data_enable_o, out, 1, data setup enable.
- weight_start_o, out, 1, one-cycle pulse that starts the weight buffer.
- weight_stop_o, out, 1, freezes weights in the systolic array.
- pass_cnt_o, out, PASS_W, current pass number, 1-based.
- busy_o, out, 1, high when state is not IDLE.
- done_o, out, 1, one-cycle pulse at job completion.

Function
REQ-004 The state machine SHALL have exactly four states: IDLE, WLOAD, STREAM, DRAIN; outputs are combinational from state, counter and inputs (Mealy).
REQ-005 IDLE: cnt is held at 0 and weight_stop_o=0; start_i=1 SHALL latch num_pass_i and mode_i, assert weight_start_o in that same cycle, and transition to WLOAD.
REQ-006 WLOAD: cnt SHALL increment by 1 per cycle; weight_stop_o=1 iff cnt>=WLOAD_CYC-1; at cnt==WLOAD_CYC, data_enable_o=1, cnt is cleared and the next state is STREAM; WLOAD therefore lasts WLOAD_CYC+1 cycles.
REQ-007 STREAM: weight_stop_o=1; data_enable_o=!stall_i unless the end condition holds; end condition = conv_done_i | (mode_lat & data_last_i); when it holds, data_enable_o=0 and the next state is DRAIN with cnt=0.
REQ-008 DRAIN: weight_stop_o=1 and data_enable_o=0; cnt increments per cycle; on the cycle where cnt==DRAIN_CYC-1, cnt is cleared and:
- If pass_cnt==effective passes: done_o=1, pass_cnt returns to 1, next state IDLE.
- Otherwise: pass_cnt increments, weight_start_o=1, next state WLOAD.
REQ-009 pass_cnt SHALL never exceed the effective pass count and SHALL never wrap.
REQ-010 abort_i=1 in any non-IDLE state SHALL take priority over every other transition: next state IDLE, cnt=0, pass_cnt=1; in that cycle data_enable_o, weight_start_o and done_o are all 0.
REQ-011 start_i SHALL be ignored outside IDLE; in IDLE, abort_i SHALL be ignored.
REQ-012 When stall_i and the end condition are both high in STREAM, the end condition SHALL win and the transition to DRAIN occurs.
REQ-013 Outside the cases stated above, data_enable_o, weight_start_o and done_o SHALL be 0.

Reset
REQ-014 rst=1 SHALL force state=IDLE, cnt=0, pass_cnt=1 and both latched settings to 0, overriding every other input, including mid-operation.
REQ-015 In the first cycle after reset, all outputs SHALL be 0 except pass_cnt_o=1.
REQ-016 A start_i asserted together with rst SHALL be dropped.

Verification (defaults: WLOAD_CYC=28, DRAIN_CYC=16)
REQ-017 Single pass, mode 0: start_i at cycle 0 with num_pass_i=1, conv_done_i at cycle 40 -> weight_start_o at cycle 0; weight_stop_o high from cycle 28; data_enable_o high cycles 29-39 and low at 40; done_o at cycle 56; busy_o low from cycle 57.
REQ-018 Three passes: num_pass_i=3, with conv_done_i 10 cycles into each STREAM -> weight_start_o pulses exactly 3 times; pass_cnt_o steps 1,2,3; done_o pulses once; pass_cnt_o=1 afterwards.
REQ-019 Mode 1: data_last_i at the 5th STREAM cycle with conv_done_i=0 -> data_enable_o drops in that same cycle and DRAIN follows; with mode 0, the same stimulus leaves data_enable_o high.
REQ-020 Stall: stall_i high for 3 STREAM cycles -> data_enable_o low for exactly those 3 cycles with the state unchanged; stall_i held with conv_done_i -> DRAIN entered.
REQ-021 Abort and reset: abort_i at WLOAD cnt=10 -> IDLE next cycle, no done_o; rst in DRAIN of pass 2 -> all outputs at reset values next cycle; num_pass_i=0 -> exactly one pass.

Source files
------------

// File: rtl/sa_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sa_seq_ctrl
//  Brief    : Systolic-array job sequencer (weight load, stream, drain, passes)
//  Revision : 1.0
// ============================================================================
module sa_seq_ctrl #(
    parameter int WLOAD_CYC = 28,
    parameter int DRAIN_CYC = 16,
    parameter int PASS_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [PASS_W-1:0] num_pass_i,
    input  logic              mode_i,
    input  logic              stall_i,
    input  logic              data_last_i,
    input  logic              conv_done_i,
    output logic              data_enable_o,
    output logic              weight_start_o,
    output logic              weight_stop_o,
    output logic [PASS_W-1:0] pass_cnt_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int c_CNT_MAX = (WLOAD_CYC > DRAIN_CYC) ? WLOAD_CYC : DRAIN_CYC;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_WLOAD_END = c_CNT_W'(WLOAD_CYC);
    localparam logic [c_CNT_W-1:0] c_WSTOP_AT  = c_CNT_W'(WLOAD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_DRAIN_END = c_CNT_W'(DRAIN_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [PASS_W-1:0]  c_PASS_ONE  = PASS_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WLOAD  = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [PASS_W-1:0]   r_pass_cnt;
    logic [PASS_W-1:0]   r_num_pass;
    logic                r_mode;

    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [PASS_W-1:0]   w_pass_nxt;
    logic [PASS_W-1:0]   w_eff_pass;
    logic                w_stream_end;
    logic                w_start_acc;

    // A requested pass count of zero still runs one pass.
    assign w_eff_pass   = (r_num_pass == '0) ? c_PASS_ONE : r_num_pass;
    assign w_stream_end = conv_done_i | (r_mode & data_last_i);
    assign w_start_acc  = start_i & ~rst;

    assign pass_cnt_o = r_pass_cnt;
    assign busy_o     = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_pass_nxt     = r_pass_cnt;
        data_enable_o  = 1'b0;
        weight_start_o = 1'b0;
        weight_stop_o  = 1'b0;
        done_o         = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_start_acc) begin
                    weight_start_o = 1'b1;
                    w_state_nxt    = S_WLOAD;
                end
            end
            S_WLOAD: begin
                weight_stop_o = (r_cnt >= c_WSTOP_AT);
                w_cnt_nxt     = r_cnt + c_CNT_ONE;
                if (r_cnt == c_WLOAD_END) begin
                    data_enable_o = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_STREAM;
                end
            end
            S_STREAM: begin
                weight_stop_o = 1'b1;
                if (w_stream_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DRAIN;
                end else begin
                    data_enable_o = ~stall_i;
                end
            end
            S_DRAIN: begin
                weight_stop_o = 1'b1;
                w_cnt_nxt     = r_cnt + c_CNT_ONE;
                if (r_cnt == c_DRAIN_END) begin
                    w_cnt_nxt = '0;
                    if (r_pass_cnt == w_eff_pass) begin
                        done_o      = 1'b1;
                        w_pass_nxt  = c_PASS_ONE;
                        w_state_nxt = S_IDLE;
                    end else begin
                        weight_start_o = 1'b1;
                        w_pass_nxt     = r_pass_cnt + c_PASS_ONE;
                        w_state_nxt    = S_WLOAD;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides every transition and silences all pulses.
        if (abort_i && (r_state != S_IDLE)) begin
            w_state_nxt    = S_IDLE;
            w_cnt_nxt      = '0;
            w_pass_nxt     = c_PASS_ONE;
            data_enable_o  = 1'b0;
            weight_start_o = 1'b0;
            done_o         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pass_cnt <= c_PASS_ONE;
            r_num_pass <= '0;
            r_mode     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pass_cnt <= w_pass_nxt;
            if ((r_state == S_IDLE) && start_i) begin
                r_num_pass <= num_pass_i;
                r_mode     <= mode_i;
            end
        end
    end

endmodule
`default_nettype wire
